// File: rtl/score_disp_pkg.sv
// Shared types and constants for the score display reader: FSM state
// encoding, active-low seven-segment glyphs and the anode-off pattern.
package score_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLINK = 2'd1,
    ST_DROP  = 2'd2
  } disp_state_t;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  localparam logic [3:0] AN_OFF = 4'b1111;

  // Active-low one-cold anode pattern for scan slot idx.
  function automatic logic [3:0] an_select(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low seven-segment glyph; non-decimal codes show a dash.
module seg7_decode
  import score_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pure lookup; values 10..15 can only come from a corrupted score bus.
  always_comb begin
    seg = GLYPH_DASH;
    case (bcd)
      4'd0: seg = GLYPH_0;
      4'd1: seg = GLYPH_1;
      4'd2: seg = GLYPH_2;
      4'd3: seg = GLYPH_3;
      4'd4: seg = GLYPH_4;
      4'd5: seg = GLYPH_5;
      4'd6: seg = GLYPH_6;
      4'd7: seg = GLYPH_7;
      4'd8: seg = GLYPH_8;
      4'd9: seg = GLYPH_9;
      default: seg = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/score_display.sv
// Score display reader: snapshots the 4-digit BCD score once per scan frame,
// multiplexes it onto a common-anode 7-segment display with optional
// leading-zero blanking, and flashes on score rise / shows dashes on drop.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   ST_IDLE  | normal display of the snapshot
//   ST_BLINK | score rose: even phases dark, odd phases normal display
//   ST_DROP  | score fell: every slot shows a dash, blanking ignored
module score_display
  import score_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 4096,
  parameter int BLINK_DIV    = 2097152,
  parameter int FLASH_PHASES = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] score0,
  input  logic [3:0] score1,
  input  logic [3:0] score2,
  input  logic [3:0] score3,
  input  logic       blank_lz,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int PHASE_W = (FLASH_PHASES > 1) ? $clog2(FLASH_PHASES) : 1;

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(FLASH_PHASES - 1);

  disp_state_t        state, state_nxt;
  logic [SCAN_W-1:0]  scan_cnt;
  logic [1:0]         digit_idx;
  logic [15:0]        snap;
  logic [BLINK_W-1:0] blink_cnt;
  logic [PHASE_W-1:0] phase_cnt;

  logic [15:0] score_in;
  logic        scan_wrap, frame_end;
  logic        score_up, score_down, retrigger;
  logic        phase_end, episode_done;

  logic [3:0]  digit_val;
  logic [6:0]  digit_glyph;
  logic        hi3_zero, hi2_zero, hi1_zero;
  logic [3:0]  lz_mask;
  logic        slot_blank;
  logic [3:0]  norm_an;
  logic [6:0]  norm_seg;
  logic [3:0]  an_nxt;
  logic [6:0]  seg_nxt;

  assign score_in     = {score3, score2, score1, score0};
  assign scan_wrap    = (scan_cnt == SCAN_LAST);
  assign frame_end    = scan_wrap && (digit_idx == 2'd3);
  assign score_up     = score_in > snap;
  assign score_down   = score_in < snap;
  assign retrigger    = frame_end && (score_up || score_down);
  assign phase_end    = (blink_cnt == BLINK_LAST);
  assign episode_done = phase_end && (phase_cnt == PHASE_LAST);

  // Scan slot timer: each digit owns SCAN_DIV consecutive cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
    end else if (scan_wrap) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  // Digit index steps 0..3 on every slot wrap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit_idx <= 2'd0;
    end else if (scan_wrap) begin
      digit_idx <= digit_idx + 2'd1;
    end
  end

  // Snapshot the score at frame end so digits only change between frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap <= 16'h0000;
    end else if (frame_end) begin
      snap <= score_in;
    end
  end

  // Phase timer for BLINK/DROP; a new score change restarts the episode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_cnt <= '0;
      phase_cnt <= '0;
    end else if (retrigger || (state == ST_IDLE)) begin
      blink_cnt <= '0;
      phase_cnt <= '0;
    end else if (phase_end) begin
      blink_cnt <= '0;
      phase_cnt <= (phase_cnt == PHASE_LAST) ? '0 : phase_cnt + PHASE_W'(1);
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: frame-end score changes win over episode completion.
  always_comb begin
    state_nxt = state;
    if (frame_end && score_up) begin
      state_nxt = ST_BLINK;
    end else if (frame_end && score_down) begin
      state_nxt = ST_DROP;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_IDLE;
        ST_BLINK: if (episode_done) state_nxt = ST_IDLE;
        ST_DROP:  if (episode_done) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  assign digit_val = snap[{digit_idx, 2'b00} +: 4];

  seg7_decode u_decode (
    .bcd (digit_val),
    .seg (digit_glyph)
  );

  // A slot is a leading zero when it and every higher digit are zero;
  // the ones digit always shows.
  always_comb begin
    hi3_zero   = (snap[15:12] == 4'd0);
    hi2_zero   = hi3_zero && (snap[11:8] == 4'd0);
    hi1_zero   = hi2_zero && (snap[7:4] == 4'd0);
    lz_mask    = blank_lz ? {hi3_zero, hi2_zero, hi1_zero, 1'b0} : 4'b0000;
    slot_blank = lz_mask[digit_idx];
    norm_an    = slot_blank ? AN_OFF : an_select(digit_idx);
    norm_seg   = slot_blank ? GLYPH_BLANK : digit_glyph;
  end

  // Output decode per state; registered below so the pins never glitch.
  always_comb begin
    an_nxt  = AN_OFF;
    seg_nxt = GLYPH_BLANK;
    case (state)
      ST_IDLE: begin
        an_nxt  = norm_an;
        seg_nxt = norm_seg;
      end
      ST_BLINK: begin
        if (phase_cnt[0]) begin
          an_nxt  = norm_an;
          seg_nxt = norm_seg;
        end
      end
      ST_DROP: begin
        an_nxt  = an_select(digit_idx);
        seg_nxt = GLYPH_DASH;
      end
      default: begin
        an_nxt  = AN_OFF;
        seg_nxt = GLYPH_BLANK;
      end
    endcase
  end

  // Output registers; reset darkens the display immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= AN_OFF;
      seg <= GLYPH_BLANK;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

  assign dp = 1'b1;

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display with short timing parameters.
module tb_score_display;

  localparam int SCAN_DIV     = 4;
  localparam int BLINK_DIV    = 8;
  localparam int FLASH_PHASES = 4;
  localparam int EP           = BLINK_DIV * FLASH_PHASES;
  localparam int FRAME        = 4 * SCAN_DIV;
  localparam int K_IDLE  = 0;
  localparam int K_BLINK = 1;
  localparam int K_DROP  = 2;

  logic        clk;
  logic        rst;
  logic [15:0] score_in;
  logic        blank_lz;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_checks;
  int n_fail;
  int cyc;

  logic [11:0] exp_q[$];

  typedef struct packed {
    logic [15:0] score;
    logic        blz;
    logic [15:0] an_e;   // {slot3, slot2, slot1, slot0}
    logic [27:0] seg_e;  // {slot3, slot2, slot1, slot0}
  } vec_t;

  vec_t vecs[7];

  score_display #(
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_DIV    (BLINK_DIV),
    .FLASH_PHASES (FLASH_PHASES)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .score0   (score_in[3:0]),
    .score1   (score_in[7:4]),
    .score2   (score_in[11:8]),
    .score3   (score_in[15:12]),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; frame ends land on multiples of FRAME.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  // Expected {an,seg} t edges after an aligned frame-end edge.
  function automatic logic [10:0] exp_at(input int t, input int kind,
                                          input logic [15:0] sc, input logic blz);
    int slot;
    logic [3:0] an_on;
    logic [3:0] d;
    logic blank;
    slot  = ((t - 1) / SCAN_DIV) % 4;
    an_on = ~(4'b0001 << slot);
    d     = sc[slot*4 +: 4];
    blank = 1'b0;
    if (blz && slot > 0) begin
      blank = 1'b1;
      for (int k = slot; k < 4; k++)
        if (sc[k*4 +: 4] != 4'd0) blank = 1'b0;
    end
    if (kind == K_BLINK && t <= EP && (((t - 1) / BLINK_DIV) % 2) == 0)
      return {4'b1111, 7'b1111111};
    if (kind == K_DROP && t <= EP)
      return {an_on, 7'b0111111};
    if (blank)
      return {4'b1111, 7'b1111111};
    return {an_on, glyph(d)};
  endfunction

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
               name, cyc, got[11:8], got[7:1], got[0], expv[11:8], expv[7:1], expv[0]);
    end
  endtask

  // Compare outputs for offsets t_from..t_to after a frame-end edge.
  task automatic check_window(input string name, input int t_from, input int t_to,
                              input int kind, input logic [15:0] sc, input logic blz);
    for (int t = t_from; t <= t_to; t++) begin
      exp_q.push_back({exp_at(t, kind, sc, blz), 1'b1});
      @(negedge clk);
      chk(name, {an, seg, dp}, exp_q.pop_front());
    end
  endtask

  task automatic wait_frame_end();
    do @(negedge clk); while (cyc % FRAME != 0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{16'h1234, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    vecs[1] = '{16'h0A00, 1'b1, {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1111111, 7'b0111111, 7'b1000000, 7'b1000000}};
    vecs[2] = '{16'h0050, 1'b1, {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                {7'b1111111, 7'b1111111, 7'b0010010, 7'b1000000}};
    vecs[3] = '{16'h9876, 1'b1, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010}};
    vecs[4] = '{16'h0000, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000}};
    vecs[5] = '{16'h0005, 1'b1, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                {7'b1111111, 7'b1111111, 7'b1111111, 7'b0010010}};
    vecs[6] = '{16'hF00B, 1'b1, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                {7'b0111111, 7'b1000000, 7'b1000000, 7'b0111111}};

    // Reset state, then zero score with blanking: only slot 0 lights.
    rst      = 1'b0;
    score_in = 16'h0000;
    blank_lz = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {an, seg, dp}, 12'b1111_1111111_1);
    rst = 1'b1;
    check_window("zero_blank", 1, 2 * FRAME, K_IDLE, 16'h0000, 1'b1);

    // Steady-state digit patterns after any flash episode has finished.
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      score_in = vecs[v].score;
      blank_lz = vecs[v].blz;
      wait_frame_end();
      repeat (EP) @(negedge clk);
      for (int s = 0; s < 4; s++)
        for (int r = 0; r < SCAN_DIV; r++)
          exp_q.push_back({vecs[v].an_e[s*4 +: 4], vecs[v].seg_e[s*7 +: 7], 1'b1});
      for (int c = 0; c < FRAME; c++) begin
        @(negedge clk);
        chk($sformatf("vec%0d_slot%0d", v, c / SCAN_DIV), {an, seg, dp}, exp_q.pop_front());
      end
    end

    // Drop: 0120 -> 0000 shows dashes for one episode, then blanked zeros.
    score_in = 16'h0120;
    blank_lz = 1'b1;
    wait_frame_end();
    repeat (EP) @(negedge clk);
    score_in = 16'h0000;
    wait_frame_end();
    check_window("drop_dash", 1, EP + FRAME, K_DROP, 16'h0000, 1'b1);

    // Rise mid-frame 0000 -> 0001, retriggered by 0002 during phase 2.
    do @(negedge clk); while (cyc % FRAME != 6);
    score_in = 16'h0001;
    blank_lz = 1'b0;
    wait_frame_end();
    check_window("blink_first", 1, 20, K_BLINK, 16'h0001, 1'b0);
    score_in = 16'h0002;
    check_window("blink_first_tail", 21, EP, K_BLINK, 16'h0001, 1'b0);
    check_window("blink_retrigger", 1, EP + FRAME, K_BLINK, 16'h0002, 1'b0);

    // Reset in the middle of a drop episode.
    score_in = 16'h0000;
    wait_frame_end();
    check_window("drop_pre_reset", 1, 10, K_DROP, 16'h0000, 1'b0);
    rst = 1'b0;
    #1;
    chk("async_reset_mid_drop", {an, seg, dp}, 12'b1111_1111111_1);
    repeat (2) @(negedge clk);
    chk("reset_held", {an, seg, dp}, 12'b1111_1111111_1);
    score_in = 16'h0003;
    blank_lz = 1'b1;
    rst = 1'b1;
    check_window("post_reset_idle", 1, FRAME, K_IDLE, 16'h0000, 1'b1);
    check_window("post_reset_blink", 1, EP + FRAME, K_BLINK, 16'h0003, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/score_display.md
Name: score_display

Overview:
- Reader side of the 4-digit BCD score bus (score0 = ones … score3 = thousands) produced by the game scoring logic.
- Snapshots the digits once per scan frame, time-multiplexes them onto a 4-digit common-anode 7-segment display and applies optional leading-zero blanking.
- Gives visual feedback: the display blinks when the score rises and shows "----" when it drops, for example on player hit or restart.
- Sits between the score register and the board display pins.

Parameters:
- SCAN_DIV, 4096, clk cycles each digit is driven per scan slot.
- BLINK_DIV, 2097152, clk cycles per blink/hold phase.
- FLASH_PHASES, 6, number of BLINK_DIV phases in a BLINK or DROP episode.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-low
- score0  input  4  BCD ones digit
- score1  input  4  BCD tens digit
- score2  input  4  BCD hundreds digit
- score3  input  4  BCD thousands digit
- blank_lz  input  1  1 = suppress leading zeros
- an  output  4  digit anodes, active-low; an[0] = ones digit
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low; held 1 (off)

Behaviour:
- Reset (rst=0, async): an=4'b1111, seg=7'b1111111, dp=1, state=IDLE, snapshot=16'h0000, digit index=0, all counters 0. Outputs stay registered throughout.
- Scan:
  - scan counter runs 0..SCAN_DIV-1.
  - At wrap, digit index advances 0→1→2→3→0.
  - an/seg for index k are presented for exactly SCAN_DIV cycles; there is no dead time.
- Frame end is scan wrap with index==3. At frame end:
  - in = {score3,score2,score1,score0} is compared against snap as unsigned 16-bit.
  - Then snap<=in.
  - All displayed data comes from snap, so digit values change only at frame boundaries.
- Change detection (frame end only):
  - in>snap → BLINK; phase counter and phase count reload to 0. This applies even if already in BLINK or DROP.
  - in<snap → DROP; reload, also from any state.
  - in==snap → no transition.
- States:
  - IDLE: normal display.
  - BLINK: phases alternate, starting with OFF (an=1111). Even phases are off, odd phases show normal display. Each phase lasts BLINK_DIV cycles. After FLASH_PHASES phases → IDLE.
  - DROP: every slot shows dash 7'b0111111 with its anode driven, ignoring blanking. After FLASH_PHASES*BLINK_DIV cycles → IDLE.
- Glyphs:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Digit >9 → dash 0111111. A dash is never blanked.
- Leading-zero blanking (blank_lz=1):
  - Digit k∈{3,2,1} is blanked if it and every higher digit are 0. Digit 0 is never blanked.
  - A blanked slot drives an=1111 and seg=1111111 for its SCAN_DIV cycles.
- Latency:
  - Input change to snap: up to 4*SCAN_DIV cycles, taking effect at the next frame end.
  - Output registers add 1 cycle after index/state.
- Counter widths are $clog2 of their parameter (minimum 1). Counters never overflow; each wraps or reloads explicitly.
- Reset mid-BLINK/DROP: outputs blank immediately. After release the block resumes in IDLE with snap=0, so the next nonzero score causes BLINK.

Decomposition:
- Package score_disp_pkg:
  - state encoding (IDLE, BLINK, DROP);
  - glyph constants (GLYPH_0..GLYPH_9, GLYPH_DASH, GLYPH_BLANK);
  - AN_OFF.
- One sub-module: seg7_decode, combinational: 4-bit BCD in, 7-bit active-low segments out, dash for values >9.

Test Plan (SCAN_DIV=4, BLINK_DIV=8, FLASH_PHASES=4):
1. Reset, then release with scores 0000 and blank_lz=1 → an=1111/seg=1111111 while reset. Afterwards only slot 0 drives: an=1110, seg=1000000 for 4 cycles; other slots an=1111. No BLINK.
2. Score 1234 held, blank_lz=0 →
   - an=1110/0011001 ×4
   - 1101/0110000 ×4
   - 1011/0100100 ×4
   - 0111/1111001 ×4, repeating.
3. Score 0000→0001 mid-frame → at next frame end enters BLINK: 8 cycles an=1111, 8 cycles normal, repeated; IDLE after 32 cycles. Digit "1" first shows in the first on-phase.
4. Score 0120→0000 → DROP: every slot 0111111 with its anode low for 32 cycles. Then IDLE showing only an=1110/1000000 (blank_lz=1).
5. Two cases:
   - score2=4'hA, others 0, blank_lz=1 → slot 2 shows 0111111, slots 1 and 0 show 0, slot 3 blanked.
   - 0050 → an[3] and an[2] never low.
6. Two cases:
   - Increase 0001→0002 during BLINK phase 2 → phase count restarts at 0 (OFF), 32 more cycles.
   - rst=0 mid-DROP → an=1111, seg=1111111 in the same cycle; IDLE after release.
